tmds_link_sequencer: RTL

- Per-channel bring-up sequencer for the 10:1 TMDS serializer pair (master/slave OSERDESE2 plus TMDS_33 output buffer).
- Runs in the parallel (pixel) clock domain.
- Waits for a stable PLL lock, then holds the serializer reset and flushes the link with control tokens.
- Then hands over to live video: the encoded pixel symbol when DE is high, the control token when DE is low.
- Re-runs the whole sequence on loss of lock or disable.

---
 rtl/tmds_link_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/tmds_link_sequencer.sv
// Per-channel TMDS serializer bring-up sequencer in the pixel clock domain.
// It qualifies PLL lock, holds the OSERDES reset, flushes control tokens and then passes live video.
module tmds_link_sequencer #(
  parameter int LOCK_CYCLES  = 1024,
  parameter int RST_CYCLES   = 16,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       pll_locked_i,
  input  logic       de_i,
  input  logic [1:0] ctrl_i,
  input  logic [9:0] data_i,
  output logic       serdes_rst_o,
  output logic [9:0] symbol_o,
  output logic       link_ready_o,
  output logic [2:0] state_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int MAX_LR = (LOCK_CYCLES > RST_CYCLES) ? LOCK_CYCLES : RST_CYCLES;
  localparam int MAX_C  = (MAX_LR > FLUSH_CYCLES) ? MAX_LR : FLUSH_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [9:0]       TOKEN_00   = 10'b1101010100;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOCK_WAIT  = 3'd1,
    SERDES_RST = 3'd2,
    FLUSH      = 3'd3,
    RUN        = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lock_meta_p0;
  logic             lock_s;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    case (c)
      2'b00:   ctrl_token = 10'b1101010100;
      2'b01:   ctrl_token = 10'b0010101011;
      2'b10:   ctrl_token = 10'b0101010100;
      default: ctrl_token = 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] live_symbol(input logic de, input logic [1:0] c,
                                             input logic [9:0] d);
    live_symbol = de ? d : ctrl_token(c);
  endfunction

  assign state_o = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_meta_p0    <= 1'b0;
      lock_s          <= 1'b0;
      state           <= IDLE;
      cnt             <= '0;
      serdes_rst_o    <= 1'b1;
      symbol_o        <= TOKEN_00;
      link_ready_o    <= 1'b0;
      lock_loss_cnt_o <= 8'd0;
    end else begin
      // lock synchronizer stage boundary
      lock_meta_p0 <= pll_locked_i;
      lock_s       <= lock_meta_p0;

      // Abort outranks every sequencing step; only lock-caused RUN exits are counted.
      if (state != IDLE && (!lock_s || !enable_i)) begin
        if (state == RUN && !lock_s && lock_loss_cnt_o != 8'hFF)
          lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
        state        <= IDLE;
        cnt          <= '0;
        serdes_rst_o <= 1'b1;
        symbol_o     <= TOKEN_00;
        link_ready_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt          <= '0;
            serdes_rst_o <= 1'b1;
            symbol_o     <= TOKEN_00;
            link_ready_o <= 1'b0;
            if (enable_i && lock_s) state <= LOCK_WAIT;
          end
          LOCK_WAIT: begin
            if (cnt == LOCK_LAST) begin
              state <= SERDES_RST;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SERDES_RST: begin
            if (cnt == RST_LAST) begin
              state        <= FLUSH;
              cnt          <= '0;
              serdes_rst_o <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          FLUSH: begin
            if (cnt == FLUSH_LAST) begin
              state        <= RUN;
              cnt          <= '0;
              link_ready_o <= 1'b1;
              symbol_o     <= live_symbol(de_i, ctrl_i, data_i);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            symbol_o <= live_symbol(de_i, ctrl_i, data_i);
          end
          default: begin
            state        <= IDLE;
            cnt          <= '0;
            serdes_rst_o <= 1'b1;
            symbol_o     <= TOKEN_00;
            link_ready_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
